leading_count: RTL and testbench

//   Multi-cycle count-leading-zeros/ones unit for the MIPS CLZ/CLO instructions,
//   and the inverse of the datapath shifter: it derives the left-shift amount that

---
 rtl/leading_count.sv | 107 ++++++++++
 tb/tb_leading_count.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/leading_count.sv
// Multi-cycle count-leading-zeros/ones unit (MIPS CLZ/CLO).
// Walks the operand MSB-first, STEP bits per cycle, and also returns the
// operand left-normalized by the count it found (zero-filled).
module leading_count #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [WIDTH-1:0]        d,
  input  logic                    ones,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(WIDTH):0]  cnt,
  output logic [WIDTH-1:0]        norm
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] STEP_C  = CW'(STEP);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             pol_q, pol_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] norm_q, norm_d;
  logic [CW-1:0]    run_len;

  // Length of the MSB-first run of bits equal to p within one STEP-wide chunk.
  function automatic logic [CW-1:0] lead_run(input logic [STEP-1:0] top, input logic p);
    logic [CW-1:0] n;
    logic          run;
    n   = '0;
    run = 1'b1;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (run && (top[i] == p)) n = n + CW'(1);
      else                      run = 1'b0;
    end
    return n;
  endfunction

  assign run_len = lead_run(shreg_q[WIDTH-1 -: STEP], pol_q);

  // State and working registers; async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      pol_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      norm_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pol_q   <= pol_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      norm_q  <= norm_d;
    end
  end

  // Next-state: accept in IDLE/FIN, consume full chunks in RUN, finish on a
  // partial chunk or once the whole word has been examined.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pol_d   = pol_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    norm_d  = norm_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          shreg_d = d;
          pol_d   = ones;
          acc_d   = '0;
          state_d = RUN;
        end else if (state_q == FIN) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if ((run_len == STEP_C) && ((acc_q + STEP_C) < WIDTH_C)) begin
          shreg_d = shreg_q << STEP;
          acc_d   = acc_q + STEP_C;
        end else begin
          // Result registers only move here, so they hold across later operations.
          cnt_d   = acc_q + run_len;
          norm_d  = shreg_q << run_len;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);
  assign cnt  = cnt_q;
  assign norm = norm_q;

endmodule

// File: tb/tb_leading_count.sv
// Directed bench for leading_count: one STEP=1 and one STEP=4 instance.
module tb_leading_count;

  localparam int W  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start1 = 1'b0;
  logic          start4 = 1'b0;
  logic          ones = 1'b0;
  logic [W-1:0]  d = '0;
  logic          busy1, done1, busy4, done4;
  logic [CW-1:0] cnt1, cnt4;
  logic [W-1:0]  norm1, norm4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  leading_count #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .d(d), .ones(ones),
    .busy(busy1), .done(done1), .cnt(cnt1), .norm(norm1)
  );

  leading_count #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .start(start4), .d(d), .ones(ones),
    .busy(busy4), .done(done4), .cnt(cnt4), .norm(norm4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one start pulse to the chosen instance; returns at accept edge + 1.
  task automatic issue(input int which, input logic [W-1:0] dv, input logic ov);
    d    = dv;
    ones = ov;
    if (which == 4) start4 = 1'b1;
    else            start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // lat counts edges from the accepting edge (=1) to the edge raising done.
  task automatic wait_done(input string tag, input int which, input int lat0, output int lat);
    lat = lat0;
    while (!((which == 4) ? done4 : done1) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_done_seen"}, (which == 4) ? done4 : done1, 1);
  endtask

  task automatic op(input string tag, input int which, input logic [W-1:0] dv, input logic ov,
                    input logic [CW-1:0] ec, input logic [W-1:0] en, input int elat);
    int lat;
    issue(which, dv, ov);
    chk({tag, "_busy"}, (which == 4) ? busy4 : busy1, 1);
    wait_done(tag, which, 1, lat);
    chk({tag, "_cnt"},  (which == 4) ? cnt4 : cnt1, ec);
    chk({tag, "_norm"}, (which == 4) ? norm4 : norm1, en);
    chk({tag, "_lat"},  lat, elat);
    chk({tag, "_busy_at_done"}, (which == 4) ? busy4 : busy1, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, (which == 4) ? done4 : done1, 0);
  endtask

  initial begin
    int   lat;
    logic seen;
    logic stable;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_cnt",  cnt1, 0);
    chk("rst_norm", norm1, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_cnt4", cnt4, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // STEP=1
    op("clz_8000",     1, 32'h0000_8000, 1'b0, 6'd16, 32'h8000_0000, 18);
    op("clz_msb",      1, 32'h8000_0000, 1'b0, 6'd0,  32'h8000_0000, 2);
    op("clo_fff0",     1, 32'hFFF0_1234, 1'b1, 6'd12, 32'h0123_4000, 14);
    op("clo_one_lsb",  1, 32'h0000_0001, 1'b1, 6'd0,  32'h0000_0001, 2);
    op("clo_allones",  1, 32'hFFFF_FFFF, 1'b1, 6'd32, 32'h0000_0000, 33);
    op("clz_zero",     1, 32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 33);

    // STEP=4
    op("s4_clz_zero",  4, 32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 9);
    op("s4_partial",   4, 32'h0300_0000, 1'b0, 6'd6,  32'hC000_0000, 3);
    op("s4_clo_f7",    4, 32'hF7FF_FFFF, 1'b1, 6'd4,  32'h7FFF_FFF0, 3);
    op("s4_clo_all",   4, 32'hFFFF_FFFF, 1'b1, 6'd32, 32'h0000_0000, 9);

    // Reset mid-RUN on a prior nonzero result
    op("pre_rst",      1, 32'h0000_8000, 1'b0, 6'd16, 32'h8000_0000, 18);
    issue(1, 32'h0000_0001, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("midrun_busy", busy1, 1);
    rstn = 1'b0;
    #1;
    chk("midrun_rst_busy", busy1, 0);
    chk("midrun_rst_done", done1, 0);
    chk("midrun_rst_cnt",  cnt1, 0);
    chk("midrun_rst_norm", norm1, 0);
    seen = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      seen = seen | done1 | busy1;
      @(posedge clk);
      #1;
    end
    chk("midrun_no_done", seen, 0);

    // Ignored start while busy, then back-to-back issue from FIN
    issue(1, 32'h0000_8000, 1'b0);
    d      = 32'hFFFF_FFFF;
    ones   = 1'b1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("hs_busy", busy1, 1);
    wait_done("hs_first", 1, 2, lat);
    chk("hs_first_cnt",  cnt1, 16);
    chk("hs_first_norm", norm1, 32'h8000_0000);
    chk("hs_first_lat",  lat, 18);
    d      = 32'h0000_0F00;
    ones   = 1'b0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("hs_b2b_accept", busy1, 1);
    lat    = 1;
    stable = 1'b1;
    while (!done1 && lat < 100) begin
      stable = stable & (cnt1 == 6'd16) & (norm1 == 32'h8000_0000);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hs_second_done_seen", done1, 1);
    chk("hs_first_stable", stable, 1);
    chk("hs_second_cnt",  cnt1, 20);
    chk("hs_second_norm", norm1, 32'hF000_0000);
    chk("hs_second_lat",  lat, 22);
    @(posedge clk);
    #1;
    chk("hs_idle_after", done1, 0);
    chk("hs_hold_cnt",   cnt1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
